// File: rtl/csr_ip_map_pkg.sv
// Shared types and constants for the two-register CSR map: hardware-interface
// structs, register byte addresses and reset values.
package csr_ip_map_pkg;

  localparam int CSR_DATA_WIDTH = 32;

  localparam logic [2:0] REG0_ADDR = 3'h0;
  localparam logic [2:0] REG1_ADDR = 3'h4;

  localparam logic [CSR_DATA_WIDTH-1:0] REG0_RESET = '0;
  localparam logic [CSR_DATA_WIDTH-1:0] REG1_RESET = '0;

  typedef struct packed {
    logic                      we;
    logic [CSR_DATA_WIDTH-1:0] next;
  } CSR_IP_Map__REG1__in_t;

  typedef struct packed {
    CSR_IP_Map__REG1__in_t REG1;
  } CSR_IP_Map__in_t;

  typedef struct packed {
    logic [CSR_DATA_WIDTH-1:0] value;
  } CSR_IP_Map__REG__out_t;

  typedef struct packed {
    CSR_IP_Map__REG__out_t REG0;
    CSR_IP_Map__REG__out_t REG1;
  } CSR_IP_Map__out_t;

endpackage

// File: rtl/bus2master_intf.sv
// APB4 bus bundle between a master and the CSR slave, with a master-side
// clocking block and a helper that names the current bus phase.
interface Bus2Master_intf #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 32
) (
  input logic pclk,
  input logic presetn
);

  logic                  psel;
  logic                  penable;
  logic                  pwrite;
  logic [ADDR_WIDTH-1:0] paddr;
  logic [DATA_WIDTH-1:0] pwdata;
  logic [DATA_WIDTH-1:0] prdata;
  logic                  pready;
  logic                  pslverr;

  clocking master_cb @(posedge pclk);
    output psel, penable, pwrite, paddr, pwdata;
    input  pready, prdata, pslverr;
  endclocking

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pready, pslverr
  );

  modport master (
    clocking master_cb,
    input    pclk, presetn
  );

  modport monitor (
    input pclk, presetn, psel, penable, pwrite, paddr, pwdata,
          prdata, pready, pslverr
  );

  // Phase as seen on the wires: reset counts as IDLE.
  function automatic string get_state();
    if (!presetn || !psel) return "IDLE";
    if (!penable)          return "SETUP";
    return "ACCESS";
  endfunction

endinterface

// File: rtl/csr_ip_map.sv
// Register file for REG0/REG1 behind a generic req/we/addr/wdata port.
// Misaligned requests flag an error and neither write nor return data.
module csr_ip_map
  import csr_ip_map_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int CSR_ADDR_WIDTH = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      i_req,
  input  logic                      i_we,
  input  logic [CSR_ADDR_WIDTH-1:0] i_addr,
  input  logic [DATA_WIDTH-1:0]     i_wdata,
  input  CSR_IP_Map__in_t           i_hwif_in,
  output logic [DATA_WIDTH-1:0]     o_rdata,
  output logic                      o_err,
  output CSR_IP_Map__out_t          o_hwif_out
);

  logic [DATA_WIDTH-1:0] r_reg0;
  logic [DATA_WIDTH-1:0] r_reg1;
  logic                  w_aligned;
  logic                  w_hit0;
  logic                  w_hit1;

  assign w_aligned = (i_addr[1:0] == 2'b00);
  assign w_hit0    = i_req && (i_addr == CSR_ADDR_WIDTH'(REG0_ADDR));
  assign w_hit1    = i_req && (i_addr == CSR_ADDR_WIDTH'(REG1_ADDR));
  assign o_err     = i_req && !w_aligned;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg0 <= REG0_RESET;
    end else if (w_hit0 && i_we) begin
      r_reg0 <= i_wdata;
    end
  end

  // A bus write in the same cycle takes priority over the hardware load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_reg1 <= REG1_RESET;
    end else if (w_hit1 && i_we) begin
      r_reg1 <= i_wdata;
    end else if (i_hwif_in.REG1.we) begin
      r_reg1 <= i_hwif_in.REG1.next;
    end
  end

  always_comb begin
    o_rdata = '0;
    if (w_hit0) begin
      o_rdata = r_reg0;
    end else if (w_hit1) begin
      o_rdata = r_reg1;
    end
  end

  assign o_hwif_out.REG0.value = r_reg0;
  assign o_hwif_out.REG1.value = r_reg1;

endmodule

// File: rtl/apb4_csr_top.sv
// APB4 slave front end: zero-wait-state decode of SETUP/ACCESS onto the
// csr_ip_map register file, with reset forcing all bus responses low.
module apb4_csr_top
  import csr_ip_map_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 3,
  parameter int CSR_ADDR_WIDTH = 3
) (
  input  logic             clk,
  input  logic             rst,
  Bus2Master_intf.slave    apb42Master_intf,
  input  CSR_IP_Map__in_t  hwif_in,
  output CSR_IP_Map__out_t hwif_out
);

  // Handshake: a transfer completes on the rising clk edge where
  // psel & penable & pready are all high; pready is asserted for every
  // ACCESS cycle (no wait states) and pslverr is only valid alongside it.
  logic                  w_access;
  logic                  w_ready;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_paddr;
  logic [DATA_WIDTH-1:0] w_rdata;

  assign w_access = apb42Master_intf.psel && apb42Master_intf.penable;
  assign w_ready  = w_access && !rst;
  assign w_paddr  = apb42Master_intf.paddr;

  csr_ip_map #(
    .DATA_WIDTH     (DATA_WIDTH),
    .CSR_ADDR_WIDTH (CSR_ADDR_WIDTH)
  ) u_csr_ip_map (
    .clk        (clk),
    .rst        (rst),
    .i_req      (w_access),
    .i_we       (apb42Master_intf.pwrite),
    .i_addr     (w_paddr[CSR_ADDR_WIDTH-1:0]),
    .i_wdata    (apb42Master_intf.pwdata),
    .i_hwif_in  (hwif_in),
    .o_rdata    (w_rdata),
    .o_err      (w_err),
    .o_hwif_out (hwif_out)
  );

  assign apb42Master_intf.pready  = w_ready;
  assign apb42Master_intf.pslverr = w_ready && w_err;
  assign apb42Master_intf.prdata  = w_ready ? w_rdata : '0;

endmodule

// File: tb/tb_apb4_csr_top.sv
// Bench for apb4_csr_top: directed vector table, hand-written corner sequences
// and randomized transfers checked against an array-based register model.
module tb_apb4_csr_top;
  import csr_ip_map_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic presetn;
  always #5 clk = ~clk;
  assign presetn = ~rst;

  Bus2Master_intf #(.ADDR_WIDTH(3), .DATA_WIDTH(32)) bus (.pclk(clk), .presetn(presetn));
  CSR_IP_Map__in_t  hwif_in;
  CSR_IP_Map__out_t hwif_out;

  apb4_csr_top #(.DATA_WIDTH(32), .ADDR_WIDTH(3), .CSR_ADDR_WIDTH(3)) dut (
    .clk              (clk),
    .rst              (rst),
    .apb42Master_intf (bus.slave),
    .hwif_in          (hwif_in),
    .hwif_out         (hwif_out)
  );

  // ---------------- scoreboard ----------------
  int          n_cmp = 0;
  int          n_err = 0;
  logic [31:0] exp_q[$];
  logic [31:0] m_regs[2];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_bit(input string name, input logic got, input logic exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  // Reference: registers are a 2-word array indexed by byte address / 4.
  function automatic void model_xfer(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                                     input logic hwe, input logic [31:0] hn,
                                     output logic [31:0] exp_rd, output logic exp_err);
    int idx;
    idx     = int'(a) / 4;
    exp_err = (int'(a) % 4) != 0;
    exp_rd  = exp_err ? 32'h0 : m_regs[idx];
    if (hwe) m_regs[1] = hn;
    if (wr && !exp_err) m_regs[idx] = wd;
  endfunction

  // ---------------- driver ----------------
  // Entered #1 after a rising edge; leaves the bus idle #1 after the commit edge,
  // so consecutive calls produce back-to-back ACCESS -> SETUP.
  task automatic xfer(input logic wr, input logic [2:0] a, input logic [31:0] wd,
                      input logic hwe, input logic [31:0] hn,
                      output logic [31:0] rd, output logic rdy, output logic err,
                      output logic setup_rdy);
    bus.psel    = 1'b1;
    bus.penable = 1'b0;
    bus.pwrite  = wr;
    bus.paddr   = a;
    bus.pwdata  = wd;
    #1 setup_rdy = bus.pready;
    @(posedge clk); #1;
    bus.penable           = 1'b1;
    hwif_in.REG1.we   = hwe;
    hwif_in.REG1.next = hn;
    #1;
    rd  = bus.prdata;
    rdy = bus.pready;
    err = bus.pslverr;
    @(posedge clk); #1;
    bus.psel        = 1'b0;
    bus.penable     = 1'b0;
    hwif_in.REG1.we = 1'b0;
  endtask

  typedef struct {
    logic        wr;
    logic [2:0]  addr;
    logic [31:0] wdata;
    logic        chk_rd;
    logic [31:0] exp_rd;
    logic        exp_err;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t        vecs[10];
  logic [31:0] rd, mrd;
  logic        rdy, err, srdy, merr;

  initial begin
    bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
    bus.paddr = '0;  bus.pwdata = '0;
    hwif_in.REG1.we = 1'b0; hwif_in.REG1.next = '0;
    m_regs[0] = 32'h0; m_regs[1] = 32'h0;

    vecs[0] = '{1'b0, 3'h0, 32'h0,        1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
    vecs[1] = '{1'b1, 3'h0, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 3'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b1, 3'h4, 32'hCAFEBABE, 1'b0, 32'h0,        1'b0, 32'hDEADBEEF, 32'hCAFEBABE};
    vecs[4] = '{1'b0, 3'h4, 32'h0,        1'b1, 32'hCAFEBABE, 1'b0, 32'hDEADBEEF, 32'hCAFEBABE};
    vecs[5] = '{1'b0, 3'h0, 32'h0,        1'b1, 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 32'hCAFEBABE};
    vecs[6] = '{1'b1, 3'h2, 32'h12345678, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'hCAFEBABE};
    vecs[7] = '{1'b0, 3'h2, 32'h0,        1'b1, 32'h0,        1'b1, 32'hDEADBEEF, 32'hCAFEBABE};
    vecs[8] = '{1'b1, 3'h5, 32'h0F0F0F0F, 1'b0, 32'h0,        1'b1, 32'hDEADBEEF, 32'hCAFEBABE};
    vecs[9] = '{1'b0, 3'h4, 32'h0,        1'b1, 32'hCAFEBABE, 1'b0, 32'hDEADBEEF, 32'hCAFEBABE};

    // ---- reset ----
    repeat (2) @(posedge clk);
    #1;
    check("reset_reg0", hwif_out.REG0.value, 32'h0);
    check("reset_reg1", hwif_out.REG1.value, 32'h0);
    check_bit("reset_pready", bus.pready, 1'b0);
    check_bit("reset_pslverr", bus.pslverr, 1'b0);
    rst = 1'b0;

    // ---- directed table ----
    for (int i = 0; i < 10; i++) begin
      xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 32'h0, rd, rdy, err, srdy);
      model_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0, 32'h0, mrd, merr);
      check_bit($sformatf("vec%0d_setup_pready", i), srdy, 1'b0);
      check_bit($sformatf("vec%0d_pready", i), rdy, 1'b1);
      check_bit($sformatf("vec%0d_pslverr", i), err, vecs[i].exp_err);
      if (vecs[i].chk_rd) check($sformatf("vec%0d_prdata", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_reg0", i), hwif_out.REG0.value, vecs[i].exp_r0);
      check($sformatf("vec%0d_reg1", i), hwif_out.REG1.value, vecs[i].exp_r1);
    end

    // ---- stray penable without psel ----
    bus.penable = 1'b1; bus.pwrite = 1'b1; bus.paddr = 3'h0; bus.pwdata = 32'hFFFFFFFF;
    #1 check_bit("stray_pready", bus.pready, 1'b0);
    @(posedge clk); #1;
    bus.penable = 1'b0;
    check("stray_reg0", hwif_out.REG0.value, 32'hDEADBEEF);

    // ---- hardware load of REG1 ----
    hwif_in.REG1.we = 1'b1; hwif_in.REG1.next = 32'h0BADF00D;
    @(posedge clk); #1;
    hwif_in.REG1.we = 1'b0;
    m_regs[1] = 32'h0BADF00D;
    check("hwload_reg1", hwif_out.REG1.value, 32'h0BADF00D);
    xfer(1'b0, 3'h4, 32'h0, 1'b0, 32'h0, rd, rdy, err, srdy);
    check("hwload_read", rd, 32'h0BADF00D);

    // ---- bus write wins over same-cycle hardware load ----
    xfer(1'b1, 3'h4, 32'h11111111, 1'b1, 32'h0BADF00D, rd, rdy, err, srdy);
    model_xfer(1'b1, 3'h4, 32'h11111111, 1'b1, 32'h0BADF00D, mrd, merr);
    check("collide_reg1", hwif_out.REG1.value, 32'h11111111);
    check("collide_reg0", hwif_out.REG0.value, 32'hDEADBEEF);

    // ---- reset asserted in ACCESS ----
    bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
    bus.paddr = 3'h0; bus.pwdata = 32'hFFFFFFFF;
    @(posedge clk); #1;
    bus.penable = 1'b1;
    #1 check_bit("rstacc_pready_before", bus.pready, 1'b1);
    rst = 1'b1;
    #1;
    check_bit("rstacc_pready", bus.pready, 1'b0);
    check("rstacc_prdata", bus.prdata, 32'h0);
    check("rstacc_reg0", hwif_out.REG0.value, 32'h0);
    check("rstacc_reg1", hwif_out.REG1.value, 32'h0);
    bus.psel = 1'b0; bus.penable = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    m_regs[0] = 32'h0; m_regs[1] = 32'h0;
    xfer(1'b1, 3'h0, 32'h600DCAFE, 1'b0, 32'h0, rd, rdy, err, srdy);
    model_xfer(1'b1, 3'h0, 32'h600DCAFE, 1'b0, 32'h0, mrd, merr);
    check_bit("post_rst_pready", rdy, 1'b1);
    check("post_rst_reg0", hwif_out.REG0.value, 32'h600DCAFE);

    // ---- randomized traffic against the model ----
    for (int i = 0; i < 80; i++) begin
      logic        r_wr, r_hwe;
      logic [2:0]  r_a;
      logic [31:0] r_wd, r_hn;
      r_wr  = 1'($urandom_range(0, 1));
      r_a   = 3'($urandom_range(0, 7));
      r_wd  = $urandom;
      r_hn  = $urandom;
      r_hwe = ($urandom_range(0, 3) == 0);
      model_xfer(r_wr, r_a, r_wd, r_hwe, r_hn, mrd, merr);
      if (!r_wr) exp_q.push_back(mrd);
      xfer(r_wr, r_a, r_wd, r_hwe, r_hn, rd, rdy, err, srdy);
      check_bit($sformatf("rnd%0d_pready", i), rdy, 1'b1);
      check_bit($sformatf("rnd%0d_pslverr", i), err, merr);
      if (!r_wr && exp_q.size() > 0) check($sformatf("rnd%0d_prdata", i), rd, exp_q.pop_front());
      check($sformatf("rnd%0d_reg0", i), hwif_out.REG0.value, m_regs[0]);
      check($sformatf("rnd%0d_reg1", i), hwif_out.REG1.value, m_regs[1]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
